aes_encipher_block: RTL and testbench

Iterative AES encipher datapath: the forward counterpart of the existing decipher block, sharing its round-key interface and cadence. Processes one 128-bit block per `next` request using externally supplied round keys (the key memory indexes on `round`). Performs SubBytes one 32-bit word per cycle through a single forward S-box. Sits beside the decipher block under the AES core; the core muxes `new_block`/`ready` by direction.

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/aes_encipher_block_if.sv | 21 ++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes_encipher_block.sv | 150 +++++++++++++++
 tb/tb_aes_encipher_block.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, control-state encoding and round-function helpers
// used by the encipher and decipher datapaths.
package aes_pkg;

    localparam logic [3:0] AES128_ROUNDS   = 4'ha;
    localparam logic [3:0] AES256_ROUNDS   = 4'he;
    localparam logic       AES_128_BIT_KEY = 1'b0;
    localparam logic       AES_256_BIT_KEY = 1'b1;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_INIT = 2'd1,
        CTRL_SBOX = 2'd2,
        CTRL_MAIN = 2'd3
    } aes_ctrl_e;

    function automatic logic [7:0] gm2(input logic [7:0] op);
        return {op[6:0], 1'b0} ^ (8'h1b & {8{op[7]}});
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] op);
        return gm2(op) ^ op;
    endfunction

    // One state column, row 0 in the top byte.
    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
                b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] data);
        return {mixw(data[127:96]), mixw(data[95:64]), mixw(data[63:32]), mixw(data[31:0])};
    endfunction

    function automatic logic [127:0] shiftrows(input logic [127:0] data);
        logic [31:0] w0, w1, w2, w3;
        w0 = data[127:96];
        w1 = data[95:64];
        w2 = data[63:32];
        w3 = data[31:0];
        return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
                w1[31:24], w2[23:16], w3[15:8], w0[7:0],
                w2[31:24], w3[23:16], w0[15:8], w1[7:0],
                w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    endfunction

    function automatic logic [127:0] addroundkey(input logic [127:0] data, input logic [127:0] rkey);
        return data ^ rkey;
    endfunction

endpackage

// File: rtl/aes_encipher_block_if.sv
// Encipher block bus: start, key length and plaintext in; round index
// (key-memory address), state/ciphertext and ready out.
interface aes_encipher_block_if;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    modport master (
        output next, keylen, round_key, block,
        input  round, new_block, ready
    );

    modport slave (
        input  next, keylen, round_key, block,
        output round, new_block, ready
    );
endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box applied to each byte of a 32-bit word (combinational).
module aes_sbox (
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);
    // Listed from entry 0x00 into the top element, so entry i lives at index ~i.
    localparam logic [255:0][7:0] SBOX_TBL = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte-wise table lookup.
    always_comb begin
        new_sboxw = {SBOX_TBL[~sboxw[31:24]], SBOX_TBL[~sboxw[23:16]],
                     SBOX_TBL[~sboxw[15:8]],  SBOX_TBL[~sboxw[7:0]]};
    end
endmodule

// File: rtl/aes_encipher_block.sv
// Iterative AES encipher datapath, one 128-bit block per next pulse with
// externally supplied round keys. AES_ENC_PARALLEL_SBOX_EN: four S-boxes give a
// one-cycle SubBytes; otherwise one shared S-box walks the four words.
module aes_encipher_block
    import aes_pkg::*;
(
    input logic                 clk,
    input logic                 reset_n,
    aes_encipher_block_if.slave bus
);
    aes_ctrl_e    ctrl_q, ctrl_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   sword_ctr_q, sword_ctr_d;
    logic         keylen_q, keylen_d;
    logic         ready_q, ready_d;
    logic [3:0]   num_rounds_s;
    logic [127:0] sub_state_s;

`ifdef AES_ENC_PARALLEL_SBOX_EN
    aes_sbox u_sbox0 (.sboxw(state_q[127:96]), .new_sboxw(sub_state_s[127:96]));
    aes_sbox u_sbox1 (.sboxw(state_q[95:64]),  .new_sboxw(sub_state_s[95:64]));
    aes_sbox u_sbox2 (.sboxw(state_q[63:32]),  .new_sboxw(sub_state_s[63:32]));
    aes_sbox u_sbox3 (.sboxw(state_q[31:0]),   .new_sboxw(sub_state_s[31:0]));
`else
    logic [31:0] sbox_in_s;
    logic [31:0] sbox_out_s;

    aes_sbox u_sbox (.sboxw(sbox_in_s), .new_sboxw(sbox_out_s));

    // Select the state word addressed by sword_ctr for the shared S-box.
    always_comb begin
        case (sword_ctr_q)
            2'd0:    sbox_in_s = state_q[127:96];
            2'd1:    sbox_in_s = state_q[95:64];
            2'd2:    sbox_in_s = state_q[63:32];
            2'd3:    sbox_in_s = state_q[31:0];
            default: sbox_in_s = state_q[127:96];
        endcase
    end

    // Merge the substituted word back into an otherwise unchanged state.
    always_comb begin
        sub_state_s = state_q;
        case (sword_ctr_q)
            2'd0:    sub_state_s[127:96] = sbox_out_s;
            2'd1:    sub_state_s[95:64]  = sbox_out_s;
            2'd2:    sub_state_s[63:32]  = sbox_out_s;
            2'd3:    sub_state_s[31:0]   = sbox_out_s;
            default: sub_state_s         = state_q;
        endcase
    end
`endif

    // Round count follows the key length latched at start.
    always_comb begin
        case (keylen_q)
            AES_128_BIT_KEY: num_rounds_s = AES128_ROUNDS;
            AES_256_BIT_KEY: num_rounds_s = AES256_ROUNDS;
            default:         num_rounds_s = AES128_ROUNDS;
        endcase
    end

    // Control FSM: next state, round sequencing and state-register updates.
    always_comb begin
        ctrl_d      = ctrl_q;
        state_d     = state_q;
        round_d     = round_q;
        sword_ctr_d = sword_ctr_q;
        keylen_d    = keylen_q;
        ready_d     = ready_q;

        case (ctrl_q)
            CTRL_IDLE: begin
                if (bus.next) begin
                    round_d  = 4'd0;
                    keylen_d = bus.keylen;
                    ready_d  = 1'b0;
                    ctrl_d   = CTRL_INIT;
                end else begin
                    ctrl_d   = CTRL_IDLE;
                end
            end

            CTRL_INIT: begin
                state_d     = addroundkey(bus.block, bus.round_key);
                round_d     = 4'd1;
                sword_ctr_d = 2'd0;
                ctrl_d      = CTRL_SBOX;
            end

            CTRL_SBOX: begin
                state_d = sub_state_s;
`ifdef AES_ENC_PARALLEL_SBOX_EN
                sword_ctr_d = 2'd0;
                ctrl_d      = CTRL_MAIN;
`else
                sword_ctr_d = sword_ctr_q + 2'd1;
                if (sword_ctr_q == 2'd3) begin
                    ctrl_d = CTRL_MAIN;
                end else begin
                    ctrl_d = CTRL_SBOX;
                end
`endif
            end

            CTRL_MAIN: begin
                if (round_q < num_rounds_s) begin
                    state_d     = addroundkey(mixcolumns(shiftrows(state_q)), bus.round_key);
                    round_d     = round_q + 4'd1;
                    sword_ctr_d = 2'd0;
                    ctrl_d      = CTRL_SBOX;
                end else begin
                    // Final round skips MixColumns; round stays at Nr while idle.
                    state_d = addroundkey(shiftrows(state_q), bus.round_key);
                    ready_d = 1'b1;
                    ctrl_d  = CTRL_IDLE;
                end
            end

            default: begin
                ctrl_d = CTRL_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= CTRL_IDLE;
            state_q     <= 128'h0;
            round_q     <= 4'd0;
            sword_ctr_q <= 2'd0;
            keylen_q    <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            ctrl_q      <= ctrl_d;
            state_q     <= state_d;
            round_q     <= round_d;
            sword_ctr_q <= sword_ctr_d;
            keylen_q    <= keylen_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.round     = round_q;
    assign bus.new_block = state_q;
    assign bus.ready     = ready_q;

endmodule

// File: tb/tb_aes_encipher_block.sv
// Self-checking bench for aes_encipher_block: FIPS-197 vectors plus random
// blocks against a byte-level AES model; honours AES_ENC_PARALLEL_SBOX_EN.
module tb_aes_encipher_block;

`ifdef AES_ENC_PARALLEL_SBOX_EN
    localparam int SBOX_CYC = 1;
`else
    localparam int SBOX_CYC = 4;
`endif
    localparam int RST_AT = (SBOX_CYC == 1) ? 15 : 30;

    localparam logic [255:0] K_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic reset_n;
    aes_encipher_block_if bus ();

    aes_encipher_block dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0]   sbox_m [256];
    logic [31:0]  kw [60];
    logic [127:0] rk [15];
    logic [3:0]   rseq [$];
    int n_cmp = 0;
    int n_mis = 0;

    // Key memory: round key for the round the DUT currently shows.
    assign bus.round_key = rk[bus.round];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int u = 1; u < 256; u++)
                if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
            sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input logic kl);
        int nk;
        int nr;
        logic [31:0] t;
        logic [7:0] rc;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) kw[i] = 32'h0;
        for (int i = 0; i < nk; i++) kw[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = kw[i - 1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            kw[i] = kw[i - nk] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {kw[4 * r], kw[4 * r + 1], kw[4 * r + 2], kw[4 * r + 3]};
    endtask

    // Byte-array AES: s[4*col+row], column-major input.
    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic kl);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] res;
        int nr;
        nr = kl ? 14 : 10;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rk[0][127 - 8 * i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[4 * c + w] = s[4 * ((c + w) % 4) + w];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    s[4 * c + w] = (r == nr) ? t[4 * c + w] :
                        gmul(t[4 * c + w], 8'h02) ^ gmul(t[4 * c + (w + 1) % 4], 8'h03) ^
                        t[4 * c + (w + 2) % 4] ^ t[4 * c + (w + 3) % 4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    function automatic int lat_for(input logic kl);
        return 2 + (SBOX_CYC + 1) * (kl ? 14 : 10);
    endfunction

    // Starts one operation from an idle cycle (called #1 after a posedge) and
    // returns when ready is seen. lat counts cycles from the one presenting next.
    task automatic run_op(input logic [255:0] key, input logic kl, input logic [127:0] pt,
                          input int disturb_at, input int reset_at, input bit keep_next,
                          output logic [127:0] ct, output logic [127:0] exp_ct,
                          output int lat, output bit rst_hit);
        expand_key(key, kl);
        exp_ct = model_enc(pt, kl);
        rst_hit = 1'b0;
        bus.keylen = kl;
        bus.block = pt;
        bus.next = 1'b1;
        rseq.delete();
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!keep_next) bus.next = 1'b0;
            bus.keylen = kl;
            if (rseq.size() == 0 || rseq[$] != bus.round) rseq.push_back(bus.round);
            if (lat == disturb_at) begin
                bus.next = 1'b1;
                bus.keylen = ~kl;
                bus.block = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (lat == reset_at) begin
                reset_n = 1'b0;
                #1;
                rst_hit = 1'b1;
                chk("rst_ready", 128'(bus.ready), 128'd1);
                chk("rst_round", 128'(bus.round), 128'd0);
                chk("rst_new_block", bus.new_block, 128'h0);
                bus.next = 1'b0;
                @(posedge clk);
                #1;
                reset_n = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end while (!bus.ready && lat < 200);
        ct = bus.new_block;
    endtask

    logic [127:0] ct, ex, got_seq, exp_seq;
    logic [255:0] key;
    logic [127:0] pt;
    logic         kl;
    int           lat;
    bit           hit;

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t reached without finishing, limit 1000000", $time);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        bus.next = 1'b0;
        bus.keylen = 1'b0;
        bus.block = 128'h0;
        build_sbox();
        expand_key(K_C1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_ready", 128'(bus.ready), 128'd1);
        chk("reset_round", 128'(bus.round), 128'd0);
        chk("reset_new_block", bus.new_block, 128'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 C.1, then output must hold while idle.
        run_op(K_C1, 1'b0, PT_C, 0, 0, 1'b0, ct, ex, lat, hit);
        chk("c1_fips", ct, CT_C1);
        chk("c1_model", ct, ex);
        chk("c1_latency", 128'(lat), 128'(lat_for(1'b0)));
        repeat (3) @(posedge clk);
        #1;
        chk("c1_hold_block", bus.new_block, CT_C1);
        chk("c1_hold_ready", 128'(bus.ready), 128'd1);

        // FIPS-197 C.3 with round sequence 0..14.
        run_op(K_C3, 1'b1, PT_C, 0, 0, 1'b0, ct, ex, lat, hit);
        chk("c3_fips", ct, CT_C3);
        chk("c3_model", ct, ex);
        chk("c3_latency", 128'(lat), 128'(lat_for(1'b1)));
        got_seq = 128'h0;
        exp_seq = 128'h0;
        foreach (rseq[i]) got_seq = (got_seq << 4) | 128'(rseq[i]);
        for (int i = 0; i <= 14; i++) exp_seq = (exp_seq << 4) | 128'(i);
        chk("c3_round_count", 128'(rseq.size()), 128'd15);
        chk("c3_round_seq", got_seq, exp_seq);

        // Appendix B, then a back-to-back start in the first ready cycle.
        run_op(K_B, 1'b0, PT_B, 0, 0, 1'b0, ct, ex, lat, hit);
        chk("appb_fips", ct, CT_B);
        chk("appb_latency", 128'(lat), 128'(lat_for(1'b0)));
        run_op(K_C1, 1'b0, PT_C, 0, 0, 1'b0, ct, ex, lat, hit);
        chk("b2b_fips", ct, CT_C1);
        chk("b2b_latency", 128'(lat), 128'(lat_for(1'b0)));

        // next during the cycle whose edge raises ready must be ignored.
        run_op(K_B, 1'b0, PT_B, lat_for(1'b0) - 1, 0, 1'b0, ct, ex, lat, hit);
        chk("late_next_ct", ct, CT_B);
        repeat (2) @(posedge clk);
        #1;
        chk("late_next_idle_ready", 128'(bus.ready), 128'd1);
        chk("late_next_idle_block", bus.new_block, CT_B);

        // next/keylen/block disturbed mid-operation.
        run_op(K_C1, 1'b0, PT_C, 20, 0, 1'b0, ct, ex, lat, hit);
        chk("busy_next_ct", ct, CT_C1);
        chk("busy_next_latency", 128'(lat), 128'(lat_for(1'b0)));

        // Asynchronous reset mid-operation, then a clean C.1 run.
        run_op(K_C1, 1'b0, PT_C, 0, RST_AT, 1'b0, ct, ex, lat, hit);
        chk("rst_reached", 128'(hit), 128'd1);
        run_op(K_C1, 1'b0, PT_C, 0, 0, 1'b0, ct, ex, lat, hit);
        chk("post_rst_ct", ct, CT_C1);
        chk("post_rst_latency", 128'(lat), 128'(lat_for(1'b0)));

        // next held high: each operation restarts one cycle after completion.
        for (int k = 0; k < 4; k++) begin
            kl = k[0];
            key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_op(key, kl, pt, 0, 0, 1'b1, ct, ex, lat, hit);
            chk("hold_next_ct", ct, ex);
            chk("hold_next_latency", 128'(lat), 128'(lat_for(kl)));
        end
        bus.next = 1'b0;
        @(posedge clk);
        #1;

        // Random keys, key lengths and plaintexts.
        for (int k = 0; k < 6; k++) begin
            kl = 1'($urandom_range(0, 1));
            key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_op(key, kl, pt, 0, 0, 1'b0, ct, ex, lat, hit);
            chk("rand_ct", ct, ex);
            chk("rand_latency", 128'(lat), 128'(lat_for(kl)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
